// File: rtl/run_ctrl.sv
// Run controller: pulses cpu_start for START_CYCLES cycles, then counts RUN cycles until the
// processor reports done or the cycle budget runs out, and holds the result until the next go.
module run_ctrl #(
    parameter int unsigned START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        cpu_done,
    output logic        cpu_start,
    output logic        busy,
    output logic        finished,
    output logic        timed_out,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun,
        StDone
    } state_t;

    localparam logic [3:0] LastHold = 4'(START_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] count_q, count_d;
    logic        fin_q, fin_d;
    logic        tmo_q, tmo_d;
    logic        start_q, busy_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        fin_d   = fin_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle, StDone: begin
                if (go) begin
                    state_d = StStart;
                    hold_d  = 4'd0;
                    count_d = 16'd0;
                    fin_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            StStart: begin
                // cpu_done is deliberately not looked at here: a stale flag must not end the run
                if (hold_q == LastHold) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            StRun: begin
                if (cpu_done) begin
                    state_d = StDone;
                    fin_d   = 1'b1;
                end else if (count_q == TIMEOUT) begin
                    state_d = StDone;
                    tmo_d   = 1'b1;
                end else if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= 4'd0;
            count_q <= 16'd0;
            fin_q   <= 1'b0;
            tmo_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            fin_q   <= fin_d;
            tmo_q   <= tmo_d;
            // Registered from next state so the outputs line up with the state they describe
            start_q <= (state_d == StStart);
            busy_q  <= (state_d == StStart) || (state_d == StRun);
        end
    end

    assign cpu_start   = start_q;
    assign busy        = busy_q;
    assign finished    = fin_q;
    assign timed_out   = tmo_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed runs plus random traffic against a run-level reference model,
// and a second instance that exercises the full 16-bit budget.
module tb_run_ctrl;

    localparam int unsigned StartA = 2;
    localparam logic [15:0] TmoA   = 16'd20;
    localparam int unsigned StartB = 3;
    localparam logic [15:0] TmoB   = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_n, go, cpu_done;
    logic        cpu_start, busy, finished, timed_out;
    logic [15:0] cycle_count;
    logic        go_b;
    logic        cpu_start_b, busy_b, finished_b, timed_out_b;
    logic [15:0] cycle_count_b;

    always #5 clk = ~clk;

    run_ctrl #(.START_CYCLES(StartA), .TIMEOUT(TmoA)) dut_a (
        .clk(clk), .rst_n(rst_n), .go(go), .cpu_done(cpu_done),
        .cpu_start(cpu_start), .busy(busy), .finished(finished), .timed_out(timed_out),
        .cycle_count(cycle_count)
    );

    run_ctrl #(.START_CYCLES(StartB), .TIMEOUT(TmoB)) dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .cpu_done(1'b0),
        .cpu_start(cpu_start_b), .busy(busy_b), .finished(finished_b), .timed_out(timed_out_b),
        .cycle_count(cycle_count_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 start, 2 run, 3 done; start_left = start cycles still owed
    int m_phase = 0;
    int m_left  = 0;
    int m_cnt   = 0;
    bit m_fin   = 1'b0;
    bit m_tmo   = 1'b0;
    int n_start_obs = 0;

    task automatic model_step(input bit g, input bit d, input bit r);
        if (!r) begin
            m_phase = 0; m_left = 0; m_cnt = 0; m_fin = 0; m_tmo = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (g) begin
                m_phase = 1; m_left = StartA; m_cnt = 0; m_fin = 0; m_tmo = 0;
            end
        end else if (m_phase == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 2;
        end else begin
            if (d) begin
                m_phase = 3; m_fin = 1;
            end else if (m_cnt == int'(TmoA)) begin
                m_phase = 3; m_tmo = 1;
            end else if (m_cnt < 65535) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic step(input bit g, input bit d, input bit r);
        go = g; cpu_done = d; rst_n = r;
        @(posedge clk);
        model_step(g, d, r);
        #1;
        check("outputs", {12'b0, cpu_start, busy, finished, timed_out, cycle_count},
              {12'b0, m_phase == 1, m_phase == 1 || m_phase == 2, m_fin, m_tmo, m_cnt[15:0]});
        check("exclusive", {31'b0, finished & timed_out}, 32'd0);
        if (cpu_start) n_start_obs++;
    endtask

    // One run from a go pulse; done_at counts RUN cycles from 1 (0 = never)
    task automatic do_run(input int done_at, input int go_at, input bit done_hold);
        int ridx;
        ridx = 0;
        n_start_obs = 0;
        step(1'b1, done_hold, 1'b1);
        check("start_clear", {14'b0, finished, timed_out, cycle_count}, 32'd0);
        for (int i = 0; i < 200 && m_phase != 3; i++) begin
            bit g, d;
            g = 1'b0;
            d = done_hold;
            if (m_phase == 2) begin
                ridx++;
                if (ridx == done_at) d = 1'b1;
                if (ridx == go_at) g = 1'b1;
            end
            step(g, d, 1'b1);
        end
        check("run_ends", {31'b0, finished | timed_out}, 32'd1);
    endtask

    initial begin
        logic [15:0] prev;
        bit          wrapped;
        int          sb;
        int          dmax;

        go = 0; cpu_done = 0; rst_n = 0; go_b = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("reset_zero", {12'b0, cpu_start, busy, finished, timed_out, cycle_count}, 32'd0);

        do_run(10, 0, 1'b0);
        check("basic_starts", n_start_obs, StartA);
        check("basic_fin", {31'b0, finished}, 32'd1);
        check("basic_tmo", {31'b0, timed_out}, 32'd0);
        check("basic_count", {16'b0, cycle_count}, 32'd9);
        check("basic_busy", {31'b0, busy}, 32'd0);

        do_run(0, 0, 1'b0);
        check("tmo_flag", {31'b0, timed_out}, 32'd1);
        check("tmo_count", {16'b0, cycle_count}, 32'd20);
        check("tmo_fin", {31'b0, finished}, 32'd0);

        do_run(21, 0, 1'b0);
        check("tie_fin", {31'b0, finished}, 32'd1);
        check("tie_tmo", {31'b0, timed_out}, 32'd0);
        check("tie_count", {16'b0, cycle_count}, 32'd20);

        do_run(0, 0, 1'b1);
        check("stale_starts", n_start_obs, StartA);
        check("stale_fin", {31'b0, finished}, 32'd1);
        check("stale_count", {16'b0, cycle_count}, 32'd0);

        do_run(8, 3, 1'b0);
        check("b2b1_count", {16'b0, cycle_count}, 32'd7);
        do_run(5, 0, 1'b0);
        check("b2b2_count", {16'b0, cycle_count}, 32'd4);
        check("b2b2_fin", {31'b0, finished}, 32'd1);

        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 50 && !(m_phase == 2 && m_cnt == 7); i++) step(1'b0, 1'b0, 1'b1);
        check("midrst_count7", {16'b0, cycle_count}, 32'd7);
        step(1'b1, 1'b0, 1'b0);
        check("midrst_zero", {12'b0, cpu_start, busy, finished, timed_out, cycle_count}, 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("midrst_idle", {31'b0, busy}, 32'd0);
        do_run(3, 0, 1'b0);
        check("midrst_rerun", {16'b0, cycle_count}, 32'd2);

        dmax = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) dmax = (i % 1500 == 0) ? 3 : ((i % 1500 == 500) ? 9 : 40);
            step($urandom_range(7) == 0, $urandom_range(dmax) == 0, $urandom_range(99) != 0);
        end

        step(1'b0, 1'b0, 1'b1);
        go_b = 1'b1;
        @(posedge clk);
        #1;
        go_b = 1'b0;
        prev = 16'd0;
        wrapped = 1'b0;
        sb = 0;
        for (int i = 0; i < 70000 && !timed_out_b; i++) begin
            if (cpu_start_b) sb++;
            if (cycle_count_b < prev) wrapped = 1'b1;
            prev = cycle_count_b;
            @(posedge clk);
            #1;
        end
        check("sat_starts", sb, StartB);
        check("sat_tmo", {31'b0, timed_out_b}, 32'd1);
        check("sat_fin", {31'b0, finished_b}, 32'd0);
        check("sat_count", {16'b0, cycle_count_b}, {16'b0, TmoB});
        check("sat_nowrap", {31'b0, wrapped}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold", {16'b0, cycle_count_b}, {16'b0, TmoB});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
